fpu_fp64_to_fp32: RTL and testbench

- Pipelined double-to-single narrowing converter for the FPU. Takes an IEEE-754 binary64 operand and returns binary32 with rounding and exception flags.
- Used by the FPU store and convert paths (FCNVDS / single-precision writeback). Complements the existing single-to-double widening path.
- Two-stage pipeline with valid/ready handshake on both sides. Full throughput of one conversion per cycle when not stalled.

---
 rtl/fpu_fp64_to_fp32_if.sv | 37 +++
 rtl/fpu_fp64_to_fp32.sv | 148 ++++++++++++++
 tb/tb_fpu_fp64_to_fp32.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_fp64_to_fp32_if.sv
// Handshake bundle for the binary64 -> binary32 narrowing converter.
// master drives operands and consumes results; slave is the converter.
interface fpu_fp64_to_fp32_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dst;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;

  modport master (
    output in_valid,
    output src,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  dst,
    input  flag_ovf,
    input  flag_unf,
    input  flag_inx
  );

  modport slave (
    input  in_valid,
    input  src,
    input  out_ready,
    output in_ready,
    output out_valid,
    output dst,
    output flag_ovf,
    output flag_unf,
    output flag_inx
  );
endinterface

// File: rtl/fpu_fp64_to_fp32.sv
// Two-stage binary64 -> binary32 narrowing converter (unpack, round/pack).
// Define FPU_FP64TO32_RNE_EN for round-to-nearest-even; default truncates.
module fpu_fp64_to_fp32 (
  input logic              clk,
  input logic              reset,
  fpu_fp64_to_fp32_if.slave io
);

  typedef enum logic [2:0] {
    C_ZERO,
    C_INFNAN,
    C_OVF,
    C_UNF,
    C_NORM
  } cls_e;

  typedef struct packed {
    logic        s;
    logic [11:0] eb;
    logic [22:0] m;
    logic        g;
    logic        st;
    logic        nan;
    cls_e        cls;
  } s1_t;

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_load;
  logic        s2_load;
  s1_t         s1_d;
  s1_t         s1_q;
  logic [10:0] e;

  logic [31:0] dst_d;
  logic [31:0] dst_q;
  logic [2:0]  flg_d;
  logic [2:0]  flg_q;

  logic        inc;
  logic [23:0] sum;
  logic [11:0] ebr;
  logic [22:0] mr;

  assign s2_load     = !s2_valid || io.out_ready;
  assign s1_load     = !s1_valid || s2_load;
  assign io.in_ready = s1_load;

  assign io.out_valid = s2_valid;
  assign io.dst       = dst_q;
  assign io.flag_ovf  = flg_q[2];
  assign io.flag_unf  = flg_q[1];
  assign io.flag_inx  = flg_q[0];

  assign e = io.src[62:52];

  always_comb begin
    s1_d     = '0;
    s1_d.s   = io.src[63];
    s1_d.eb  = {1'b0, e} - 12'd896;
    s1_d.m   = io.src[51:29];
    s1_d.g   = io.src[28];
    s1_d.st  = |io.src[27:0];
    s1_d.nan = (e == 11'h7ff) && (|io.src[51:0]);
    // denormal inputs collapse into ZERO
    unique case (1'b1)
      (e == 11'd0):
        s1_d.cls = C_ZERO;
      (e == 11'h7ff):
        s1_d.cls = C_INFNAN;
      (e >= 11'd1151) && (e != 11'h7ff):
        s1_d.cls = C_OVF;
      (e != 11'd0) && (e <= 11'd896):
        s1_d.cls = C_UNF;
      default:
        s1_d.cls = C_NORM;
    endcase
  end

  always_comb begin
`ifdef FPU_FP64TO32_RNE_EN
    inc = s1_q.g && (s1_q.st || s1_q.m[0]);
`else
    inc = 1'b0;
`endif
    sum = {1'b0, s1_q.m} + {23'd0, inc};
    ebr = s1_q.eb + {11'd0, sum[23]};
    mr  = sum[23] ? 23'd0 : sum[22:0];
  end

  always_comb begin
    dst_d = '0;
    flg_d = '0;
    unique case (s1_q.cls)
      C_ZERO: begin
        dst_d = {s1_q.s, 31'd0};
      end
      C_INFNAN: begin
        if (s1_q.nan)
          dst_d = {s1_q.s, 8'hff, 1'b1, s1_q.m[21:0]};
        else
          dst_d = {s1_q.s, 8'hff, 23'd0};
      end
      C_OVF: begin
        dst_d = {s1_q.s, 8'hff, 23'd0};
        flg_d = 3'b101;
      end
      C_UNF: begin
        dst_d = {s1_q.s, 31'd0};
        flg_d = 3'b011;
      end
      default: begin
        flg_d[0] = s1_q.g | s1_q.st;
        // mantissa carry can push the biased exponent to 255
        if (ebr == 12'd255) begin
          dst_d    = {s1_q.s, 8'hff, 23'd0};
          flg_d[2] = 1'b1;
        end else begin
          dst_d = {s1_q.s, ebr[7:0], mr};
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      dst_q    <= '0;
      flg_q    <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= io.in_valid;
        if (io.in_valid)
          s1_q <= s1_d;
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          dst_q <= dst_d;
          flg_q <= flg_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_fp64_to_fp32.sv
// Directed bench for fpu_fp64_to_fp32: values, specials, stalls, reset.
// Expectations follow the build selected by FPU_FP64TO32_RNE_EN.
module tb_fpu_fp64_to_fp32;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fpu_fp64_to_fp32_if io ();

  fpu_fp64_to_fp32 dut (
    .clk   (clk),
    .reset (reset),
    .io    (io.slave)
  );

  function automatic logic [2:0] flags();
    return {io.flag_ovf, io.flag_unf, io.flag_inx};
  endfunction

  task automatic test_reset();
    reset        = 1'b1;
    io.in_valid  = 1'b0;
    io.src       = '0;
    io.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if (io.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", io.out_valid);
    end
    checks++;
    if (io.dst !== 32'h0) begin
      failures++;
      $display("FAIL reset_dst got=%h exp=00000000", io.dst);
    end
    checks++;
    if (flags() !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000", flags());
    end
    checks++;
    if (io.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", io.in_ready);
    end
  endtask

  // one operand into an idle pipe; result checked two edges later
  task automatic conv(input logic [63:0] v, input logic [31:0] ed,
                      input logic [2:0] ef, input string nm);
    io.in_valid  = 1'b1;
    io.src       = v;
    io.out_ready = 1'b1;
    #1;
    checks++;
    if (io.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready got=%b exp=1", nm, io.in_ready);
    end
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    io.src = '0;
    checks++;
    if (io.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s early_valid got=%b exp=0", nm, io.out_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (io.out_valid !== 1'b1 || io.dst !== ed || flags() !== ef) begin
      failures++;
      $display("FAIL %s valid=%b dst=%h exp=%h flags=%b exp=%b",
               nm, io.out_valid, io.dst, ed, flags(), ef);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    conv(64'h3FF0000000000000, 32'h3F800000, 3'b000, "one");
    conv(64'h3810000000000000, 32'h00800000, 3'b000, "min_norm");
    conv(64'h47EFFFFFE0000000, 32'h7F7FFFFF, 3'b000, "max_norm");
  endtask

  task automatic test_rounding();
    conv(64'h3FF0000010000000, 32'h3F800000, 3'b001, "tie_even");
`ifdef FPU_FP64TO32_RNE_EN
    conv(64'h3FF0000030000000, 32'h3F800002, 3'b001, "tie_odd");
    conv(64'h3FF0000018000000, 32'h3F800001, 3'b001, "above_half");
    conv(64'h47EFFFFFF0000000, 32'h7F800000, 3'b101, "round_ovf");
`else
    conv(64'h3FF0000030000000, 32'h3F800001, 3'b001, "tie_odd");
    conv(64'h3FF0000018000000, 32'h3F800000, 3'b001, "above_half");
    conv(64'h47EFFFFFF0000000, 32'h7F7FFFFF, 3'b001, "round_ovf");
`endif
  endtask

  task automatic test_specials();
    conv(64'h3800000000000000, 32'h00000000, 3'b011, "unf_pos");
    conv(64'hB800000000000000, 32'h80000000, 3'b011, "unf_neg");
    conv(64'h7FF0000000000001, 32'h7FC00000, 3'b000, "nan");
    conv(64'h7FF8000020000000, 32'h7FC00001, 3'b000, "nan_pay");
    conv(64'hFFF0000000000000, 32'hFF800000, 3'b000, "neg_inf");
    conv(64'h0000000000000001, 32'h00000000, 3'b000, "denorm");
    conv(64'h47F0000000000000, 32'h7F800000, 3'b101, "ovf_cls");
  endtask

  task automatic test_back_to_back();
    logic [63:0] ops [4];
    logic [31:0] exp [4];
    int acc = 0;
    int got = 0;
    int cyc = 0;
    bit drop_seen = 1'b0;
    bit ir;
    ops[0] = 64'h3FF0000000000000; exp[0] = 32'h3F800000;
    ops[1] = 64'h4000000000000000; exp[1] = 32'h40000000;
    ops[2] = 64'hC008000000000000; exp[2] = 32'hC0400000;
    ops[3] = 64'h3FE0000000000000; exp[3] = 32'h3F000000;
    while (got < 4 && cyc < 60) begin
      io.in_valid  = (acc < 4);
      io.src       = (acc < 4) ? ops[acc] : 64'h0;
      io.out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      ir = io.in_ready;
      if (!ir && io.in_valid && !drop_seen) begin
        drop_seen = 1'b1;
        checks++;
        if (acc != 2) begin
          failures++;
          $display("FAIL b2b_drop accepts=%0d exp=2", acc);
        end
      end
      if (io.out_valid && !io.out_ready) begin
        checks++;
        if (io.dst !== exp[got]) begin
          failures++;
          $display("FAIL b2b_hold dst=%h exp=%h", io.dst, exp[got]);
        end
      end
      if (io.out_valid && io.out_ready) begin
        checks++;
        if (io.dst !== exp[got] || flags() !== 3'b000) begin
          failures++;
          $display("FAIL b2b_out%0d dst=%h exp=%h flags=%b",
                   got, io.dst, exp[got], flags());
        end
        got++;
      end
      if (io.in_valid && ir)
        acc++;
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (got != 4 || !drop_seen) begin
      failures++;
      $display("FAIL b2b_done got=%0d exp=4 drop_seen=%b exp=1",
               got, drop_seen);
    end
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) begin
      #1;
      checks++;
      if (io.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL b2b_dup out_valid=%b exp=0", io.out_valid);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_midstream();
    io.out_ready = 1'b0;
    io.in_valid  = 1'b1;
    io.src       = 64'h4000000000000000;
    @(posedge clk);
    #1 io.src = 64'h3FF0000000000000;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b1;
    checks++;
    if (io.out_valid !== 1'b0 || io.dst !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset valid=%b exp=0 dst=%h exp=00000000",
               io.out_valid, io.dst);
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (io.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale valid=%b exp=0 dst=%h",
                 io.out_valid, io.dst);
      end
    end
    conv(64'h3FF0000000000000, 32'h3F800000, 3'b000, "post_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
